// File: rtl/vec_pkg.sv
// Shared definitions for the vector issue sequencer: opcode, FSM states and default geometry.
package vec_pkg;

  localparam logic [6:0] VEC_OP = 7'b1010111;

  localparam int unsigned NUM_ELEM_DEF = 8;
  localparam int unsigned LANES_DEF    = 2;
  localparam int unsigned LAT_DEF      = 2;

  localparam int unsigned IDX_W_DEF = $clog2(NUM_ELEM_DEF);
  localparam int unsigned VL_W_DEF  = $clog2(NUM_ELEM_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } vec_state_e;

endpackage

// File: rtl/vec_inflight_pipe.sv
// Fixed-latency shadow of the vector ALU: tracks {valid,idx,mask} of each accepted group
// so the tail stage lines up with the ALU result for write-back.
module vec_inflight_pipe
  import vec_pkg::*;
#(
  parameter int unsigned LAT   = LAT_DEF,
  parameter int unsigned IDXW  = IDX_W_DEF,
  parameter int unsigned LANES = LANES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [IDXW-1:0]  push_idx_i,
  input  logic [LANES-1:0] push_mask_i,
  output logic             tail_valid_o,
  output logic [IDXW-1:0]  tail_idx_o,
  output logic [LANES-1:0] tail_mask_o,
  output logic             pending_o
);

  logic [LAT-1:0]   vld_q;
  logic [IDXW-1:0]  idx_q  [LAT];
  logic [LANES-1:0] mask_q [LAT];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        idx_q[s]  <= '0;
        mask_q[s] <= '0;
      end
    end else begin
      vld_q[0]  <= push_i && !flush_i;
      idx_q[0]  <= push_idx_i;
      mask_q[0] <= push_mask_i;
      for (int unsigned s = 1; s < LAT; s++) begin
        vld_q[s]  <= vld_q[s-1] && !flush_i;
        idx_q[s]  <= idx_q[s-1];
        mask_q[s] <= mask_q[s-1];
      end
    end
  end

  // Groups still ahead of the tail; once none remain the current tail is the last write-back.
  always_comb begin
    pending_o = 1'b0;
    for (int unsigned s = 0; s + 1 < LAT; s++) begin
      pending_o = pending_o | vld_q[s];
    end
  end

  assign tail_valid_o = vld_q[LAT-1];
  assign tail_idx_o   = idx_q[LAT-1];
  assign tail_mask_o  = mask_q[LAT-1];

endmodule

// File: rtl/vec_issue_ctrl.sv
// Vector-op sequencer: freezes IF/ID, issues LANES-wide element groups to the vector ALU
// and drives VRF write-back from the fixed-latency in-flight pipe.
module vec_issue_ctrl
  import vec_pkg::*;
#(
  parameter int unsigned NUM_ELEM = NUM_ELEM_DEF,
  parameter int unsigned LANES    = LANES_DEF,
  parameter int unsigned LAT      = LAT_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          inst_valid_i,
  input  logic [6:0]                    Op_i,
  input  logic [$clog2(NUM_ELEM+1)-1:0] vl_i,
  input  logic                          flush_i,
  input  logic                          alu_ready_i,
  output logic                          stall_o,
  output logic                          issue_valid_o,
  output logic [$clog2(NUM_ELEM)-1:0]   issue_idx_o,
  output logic [LANES-1:0]              issue_mask_o,
  output logic                          wb_valid_o,
  output logic [$clog2(NUM_ELEM)-1:0]   wb_idx_o,
  output logic [LANES-1:0]              wb_mask_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned IW = $clog2(NUM_ELEM);
  localparam int unsigned VW = $clog2(NUM_ELEM + 1);
  localparam int unsigned SW = VW + 1;

  vec_state_e state_q, state_d;

  logic [VW-1:0]    vl_q, vl_in;
  logic [IW-1:0]    idx_q;
  logic [SW-1:0]    next_base;
  logic [LANES-1:0] mask;
  logic             accept, xfer, last_grp, pending;
  logic             tail_vld;
  logic [IW-1:0]    tail_idx;
  logic [LANES-1:0] tail_mask;

  assign accept = (state_q == IDLE) && inst_valid_i && (Op_i == VEC_OP) && !flush_i;
  assign xfer   = (state_q == ISSUE) && alu_ready_i;

  // Sums are one bit wider than vl so idx+LANES past NUM_ELEM cannot wrap.
  always_comb begin
    vl_in     = (vl_i > VW'(NUM_ELEM)) ? VW'(NUM_ELEM) : vl_i;
    next_base = SW'(idx_q) + SW'(LANES);
    last_grp  = next_base >= SW'(vl_q);
    mask      = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      mask[l] = (SW'(idx_q) + SW'(l)) < SW'(vl_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stall_o       = accept;
    issue_valid_o = 1'b0;
    issue_idx_o   = '0;
    issue_mask_o  = '0;
    done_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = (vl_in != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        stall_o       = 1'b1;
        issue_valid_o = 1'b1;
        issue_idx_o   = idx_q;
        issue_mask_o  = mask;
        if (flush_i)                    state_d = IDLE;
        else if (alu_ready_i && last_grp) state_d = DRAIN;
      end
      DRAIN: begin
        stall_o = 1'b1;
        if (flush_i)       state_d = IDLE;
        else if (!pending) state_d = DONE;
      end
      DONE: begin
        done_o  = !flush_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vl_q  <= '0;
      idx_q <= '0;
    end else if (accept) begin
      vl_q  <= vl_in;
      idx_q <= '0;
    end else if (xfer) begin
      idx_q <= idx_q + IW'(LANES);
    end
  end

  vec_inflight_pipe #(
    .LAT   (LAT),
    .IDXW  (IW),
    .LANES (LANES)
  ) u_pipe (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_i       (xfer),
    .push_idx_i   (idx_q),
    .push_mask_i  (mask),
    .tail_valid_o (tail_vld),
    .tail_idx_o   (tail_idx),
    .tail_mask_o  (tail_mask),
    .pending_o    (pending)
  );

  assign busy_o     = (state_q != IDLE);
  assign wb_valid_o = tail_vld && !flush_i;
  assign wb_idx_o   = wb_valid_o ? tail_idx  : '0;
  assign wb_mask_o  = wb_valid_o ? tail_mask : '0;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Bench for vec_issue_ctrl: directed scenarios plus random traffic against a
// transaction-level timeline model (group queue, write-back schedule, done time).
module tb_vec_issue_ctrl;

  localparam int NE = 8;
  localparam int LN = 2;
  localparam int LT = 2;
  localparam logic [6:0] OPV = 7'b1010111;

  logic       clk = 1'b0;
  logic       rst_i, inst_valid_i, flush_i, alu_ready_i;
  logic [6:0] Op_i;
  logic [3:0] vl_i;
  logic       stall_o, issue_valid_o, wb_valid_o, busy_o, done_o;
  logic [2:0] issue_idx_o, wb_idx_o;
  logic [1:0] issue_mask_o, wb_mask_o;

  vec_issue_ctrl #(.NUM_ELEM(NE), .LANES(LN), .LAT(LT)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .inst_valid_i  (inst_valid_i),
    .Op_i          (Op_i),
    .vl_i          (vl_i),
    .flush_i       (flush_i),
    .alu_ready_i   (alu_ready_i),
    .stall_o       (stall_o),
    .issue_valid_o (issue_valid_o),
    .issue_idx_o   (issue_idx_o),
    .issue_mask_o  (issue_mask_o),
    .wb_valid_o    (wb_valid_o),
    .wb_idx_o      (wb_idx_o),
    .wb_mask_o     (wb_mask_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: op active from accept through its done cycle.
  bit         act = 1'b0;
  int         done_at = -1;
  logic [2:0] q_idx[$];
  logic [1:0] q_mask[$];
  logic [2:0] wb_idx_at[int];
  logic [1:0] wb_mask_at[int];

  int stall_seen, done_seen, done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    act     = 1'b0;
    done_at = -1;
    q_idx.delete();
    q_mask.delete();
    wb_idx_at.delete();
    wb_mask_at.delete();
  endtask

  task automatic step(input logic iv, input logic [6:0] op, input logic [3:0] vl,
                      input logic fl, input logic rdy, input logic rs);
    logic acc, e_iv, e_wb, e_done, e_stall;
    logic [1:0] m;
    int v;
    inst_valid_i = iv; Op_i = op; vl_i = vl; flush_i = fl; alu_ready_i = rdy; rst_i = rs;
    #4;
    acc     = !act && iv && (op == OPV) && !fl;
    e_iv    = act && (q_idx.size() > 0);
    e_wb    = wb_idx_at.exists(cyc) && !fl;
    e_done  = act && (cyc == done_at) && !fl;
    e_stall = acc || (act && (cyc != done_at));
    chk("stall", stall_o, e_stall);
    chk("busy", busy_o, act);
    chk("issue_valid", issue_valid_o, e_iv);
    chk("wb_valid", wb_valid_o, e_wb);
    chk("done", done_o, e_done);
    if (e_iv) begin
      chk("issue_idx", issue_idx_o, q_idx[0]);
      chk("issue_mask", issue_mask_o, q_mask[0]);
    end
    if (e_wb) begin
      chk("wb_idx", wb_idx_o, wb_idx_at[cyc]);
      chk("wb_mask", wb_mask_o, wb_mask_at[cyc]);
    end
    stall_seen += int'(stall_o);
    if (done_o) begin
      done_seen = cyc;
      done_cnt++;
    end
    if (!rs || (fl && act)) begin
      model_clear();
    end else begin
      if (wb_idx_at.exists(cyc)) begin
        wb_idx_at.delete(cyc);
        wb_mask_at.delete(cyc);
      end
      if (e_iv && rdy) begin
        wb_idx_at[cyc+LT]  = q_idx.pop_front();
        wb_mask_at[cyc+LT] = q_mask.pop_front();
        if (q_idx.size() == 0) done_at = cyc + LT + 1;
      end
      if (act && cyc == done_at) begin
        act     = 1'b0;
        done_at = -1;
      end
      if (acc) begin
        act = 1'b1;
        v   = (int'(vl) > NE) ? NE : int'(vl);
        for (int b = 0; b < v; b += LN) begin
          m = '0;
          for (int l = 0; l < LN; l++) if (b + l < v) m[l] = 1'b1;
          q_idx.push_back(b[2:0]);
          q_mask.push_back(m);
        end
        done_at = (v == 0) ? cyc + 1 : -1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic mark();
    stall_seen = 0;
    done_seen  = -1;
    done_cnt   = 0;
  endtask

  int t0;

  initial begin
    rst_i = 1'b0; inst_valid_i = 1'b0; Op_i = '0; vl_i = '0; flush_i = 1'b0; alu_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle(2);

    // Full vector, no backpressure
    mark(); t0 = cyc;
    step(1'b1, OPV, 4'd8, 1'b0, 1'b1, 1'b1);
    idle(9);
    chk("s1_stall_cycles", stall_seen, 7);
    chk("s1_done_cycle", done_seen - t0, 7);

    // ALU backpressure in cycles 2-3
    mark(); t0 = cyc;
    step(1'b1, OPV, 4'd8, 1'b0, 1'b1, 1'b1);
    step(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(8);
    chk("s2_done_cycle", done_seen - t0, 9);

    // Partial group, clamp, empty vector
    step(1'b1, OPV, 4'd5, 1'b0, 1'b1, 1'b1);
    idle(8);
    step(1'b1, OPV, 4'd9, 1'b0, 1'b1, 1'b1);
    idle(9);
    mark(); t0 = cyc;
    step(1'b1, OPV, 4'd0, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("s3_vl0_done_cycle", done_seen - t0, 1);

    // Flush in cycle 3
    mark();
    step(1'b1, OPV, 4'd8, 1'b0, 1'b1, 1'b1);
    idle(2);
    step(1'b0, 7'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    idle(6);
    chk("s4_no_done", done_seen, -1);

    // Vector op held in ID across DONE
    mark();
    for (int i = 0; i < 16; i++) step(1'b1, OPV, 4'd4, 1'b0, 1'b1, 1'b1);
    chk("s5_done_pulses", done_cnt, 2);
    idle(8);

    // Reset while draining, then a fresh op
    step(1'b1, OPV, 4'd8, 1'b0, 1'b1, 1'b1);
    idle(4);
    step(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(1);
    mark();
    step(1'b1, OPV, 4'd6, 1'b0, 1'b1, 1'b1);
    idle(8);
    chk("s6_op_after_reset", done_cnt, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op_r;
      op_r = ($urandom % 5 == 0) ? 7'($urandom) : OPV;
      step(1'($urandom % 2), op_r, 4'($urandom_range(0, 15)), ($urandom % 30) == 0,
           ($urandom % 10) < 7, ($urandom % 80) != 0);
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
